// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: start, 8 data bits LSB first, optional even parity, stop.
// Define UART_RX_PARITY_EN for the 11-bit frame with parity; leave it undefined for a 10-bit frame.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HalfM1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FullM1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitIdle
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitidx;
    logic [7:0]    shreg;
    logic          sync1;
    logic          rx_s;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= '0;
            bitidx     <= '0;
            shreg      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        state <= StStart;
                        cnt   <= '0;
                    end
                end
                // First sample lands half a cell after detection, later ones a full cell apart.
                StStart: begin
                    if (cnt == HalfM1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= StIdle;
                        end else begin
                            state  <= StData;
                            bitidx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: begin
                    if (cnt == FullM1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end else begin
                            bitidx <= bitidx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt == FullM1) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= StStop;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (cnt == FullM1) begin
                        cnt       <= '0;
                        valid     <= 1'b1;
                        data_out  <= shreg;
                        frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bit ^ (^shreg);
`endif
                        // A low stop bit may be a break; wait for the line to recover.
                        state <= rx_s ? StIdle : StWaitIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (rx_s) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
